level_tracker: RTL and testbench
================================

Name: level_tracker

Overview:
- Downstream of the player-movement block. Consumes the player row and a collision flag from the car/lane logic.
- Detects each completed crossing, i.e. the player reaching the goal row.
- Maintains a level counter 0..MAX_LEVEL, drives the level digit on the 7-segment display, and publishes level/game-state for the lane-speed and render logic.

Parameters:
- GOAL_ROW, 1: row value that counts as a completed crossing.
- MAX_LEVEL, 9: highest level; must be ≤ 9 (single BCD digit).
- FLASH_CYCLES, 12500000: length of the LEVEL_UP / GAME_OVER display phase, in i_Clk cycles (0.5 s at 25 MHz).

Ports:
- i_Clk, input, 1: system clock.
- i_reset, input, 1: synchronous, active-high reset.
- i_player_y, input, 4: current player row (1..15).
- i_collision, input, 1: level-sensitive; high while player overlaps a car.
- o_level, output, 4: current level, binary 0..MAX_LEVEL.
- o_level_up, output, 1: one-cycle pulse on each level increment.
- o_game_over, output, 1: high throughout the GAME_OVER phase.
- o_win, output, 1: high in WIN state.
- o_segment1, output, 7: left digit, active-low, bit6=A .. bit0=G.
- o_segment2, output, 7: right digit (level), same encoding.

Behaviour:
- Clock and reset: single clock i_Clk. Reset i_reset is synchronous, active-high, and takes priority over everything.
- Reset values:
  - state=PLAYING, o_level=0, o_level_up=0, o_game_over=0, o_win=0.
  - Flash counter=0, r_at_goal=0.
  - o_segment2 shows "0" (7'b0000001); o_segment1 blank (7'h7F).
- Goal event: goal = (i_player_y==GOAL_ROW) && !r_at_goal, where r_at_goal is i_player_y==GOAL_ROW registered every cycle. A single-cycle goal row therefore yields exactly one event.
- Latency: all outputs are registered. The effect of an event sampled at edge N is visible after edge N.
- States:
  - PLAYING:
    - collision → GAME_OVER: o_level←0, counter←0.
    - Otherwise goal with o_level<MAX_LEVEL → LEVEL_UP: o_level←o_level+1, o_level_up=1 for one cycle, counter←0.
    - Otherwise goal with o_level==MAX_LEVEL → WIN.
  - LEVEL_UP:
    - Counter increments each cycle.
    - o_segment2 blank while counter<FLASH_CYCLES/2; shows the new level otherwise.
    - Goal events ignored.
    - collision → GAME_OVER (level←0).
    - counter==FLASH_CYCLES-1 → PLAYING.
  - GAME_OVER:
    - o_game_over=1; o_segment2 shows "0".
    - Goal and collision inputs ignored.
    - counter==FLASH_CYCLES-1 → PLAYING.
  - WIN:
    - o_win=1; o_level held at MAX_LEVEL.
    - All inputs except i_reset ignored. Exit only via i_reset.
- Simultaneous goal and collision in PLAYING: collision wins, no o_level_up.
- Counter width: ceil(log2(FLASH_CYCLES)). Counter saturates only through the state exit; it never wraps.
- Reset mid-LEVEL_UP or mid-GAME_OVER: immediate return to reset values on the same edge.
- o_level never exceeds MAX_LEVEL; no wrap to 0 except via collision or reset.

Optional Feature:
- Macro: LEVEL_TRACKER_HIGH_SCORE_EN.
- Enabled:
  - Register r_best (4 bits) is updated to o_level+1 when a level increment exceeds it.
  - r_best is cleared by i_reset only; it survives GAME_OVER.
  - o_segment1 shows r_best.
- Disabled: no r_best register; o_segment1 is constant 7'h7F (blank).

Decomposition:
- Shared package/include:
  - state encodings (PLAYING, LEVEL_UP, GAME_OVER, WIN);
  - 7-segment digit constants 0–9 and SEG_BLANK;
  - default GOAL_ROW / START_ROW board constants.
- Sub-module seven_seg_encoder: 4-bit value in, 7-bit active-low segments out, blank for values >9. Instantiated twice.

Test Plan:
- Reset then idle with i_player_y=15 → o_level=0, o_segment2=7'b0000001, all flags 0.
- i_player_y 15→1 for one cycle, then 15 → o_level=1 one cycle later; o_level_up high exactly one cycle; LEVEL_UP lasts FLASH_CYCLES (bench uses FLASH_CYCLES=8), digit blank 4 cycles then "1".
- At level 3, i_collision=1 for 1 cycle → o_level=0, o_game_over high 8 cycles, then PLAYING; a goal pulse during GAME_OVER changes nothing.
- Goal and collision asserted in the same cycle at level 2 → o_level=0, o_level_up never asserted.
- Nine crossings then a tenth → o_level=9, o_win=1; further goals and collisions ignored; i_reset → o_level=0, o_win=0.
- With LEVEL_TRACKER_HIGH_SCORE_EN: reach level 4, collide → o_segment1 still "4", o_level=0; i_reset → o_segment1 "0".

Source files
------------

// File: rtl/level_tracker_pkg.sv
// Shared constants for the level tracker: FSM states, board rows and
// active-low 7-segment glyphs (bit6=A .. bit0=G).
package level_tracker_pkg;

  typedef enum logic [1:0] {
    PLAYING   = 2'd0,
    LEVEL_UP  = 2'd1,
    GAME_OVER = 2'd2,
    WIN       = 2'd3
  } state_t;

  localparam int GOAL_ROW_DEFAULT  = 1;
  localparam int START_ROW_DEFAULT = 15;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/level_tracker_seven_seg.sv
// seven_seg_encoder: 4-bit value to active-low segments; values above 9
// render blank, which callers use as an explicit "display off" code.
module seven_seg_encoder
  import level_tracker_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_segments
);

  always_comb begin
    o_segments = SEG_BLANK;
    case (i_value)
      4'd0: o_segments = SEG_0;
      4'd1: o_segments = SEG_1;
      4'd2: o_segments = SEG_2;
      4'd3: o_segments = SEG_3;
      4'd4: o_segments = SEG_4;
      4'd5: o_segments = SEG_5;
      4'd6: o_segments = SEG_6;
      4'd7: o_segments = SEG_7;
      4'd8: o_segments = SEG_8;
      4'd9: o_segments = SEG_9;
      default: o_segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/level_tracker.sv
// Level counter / game-state FSM for the crossing game.
// Optional best-level display on the left digit: `define LEVEL_TRACKER_HIGH_SCORE_EN.
module level_tracker
  import level_tracker_pkg::*;
#(
  parameter int GOAL_ROW     = GOAL_ROW_DEFAULT,
  parameter int MAX_LEVEL    = 9,
  parameter int FLASH_CYCLES = 12500000
)
(
  input  logic       i_Clk,
  input  logic       i_reset,
  input  logic [3:0] i_player_y,
  input  logic       i_collision,
  output logic [3:0] o_level,
  output logic       o_level_up,
  output logic       o_game_over,
  output logic       o_win,
  output logic [6:0] o_segment1,
  output logic [6:0] o_segment2
);

  localparam int             CW       = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(FLASH_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(FLASH_CYCLES / 2);
  localparam logic [3:0]     LVL_MAX  = 4'(MAX_LEVEL);
  localparam logic [3:0]     GOAL_Y   = 4'(GOAL_ROW);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_level;
  logic          r_level_up;
  logic          r_at_goal;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_level_nxt;
  logic          w_level_up_nxt;
  logic          w_goal;
  logic [3:0]    w_digit1;
  logic [3:0]    w_digit2;

  // Rising-edge detect on the goal row so a held goal counts once.
  assign w_goal = (i_player_y == GOAL_Y) && !r_at_goal;

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      r_state    <= PLAYING;
      r_cnt      <= '0;
      r_level    <= 4'd0;
      r_level_up <= 1'b0;
      r_at_goal  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_level    <= w_level_nxt;
      r_level_up <= w_level_up_nxt;
      r_at_goal  <= (i_player_y == GOAL_Y);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_level_nxt    = r_level;
    w_level_up_nxt = 1'b0;
    case (r_state)
      PLAYING: begin
        if (i_collision) begin
          w_state_nxt = GAME_OVER;
          w_level_nxt = 4'd0;
          w_cnt_nxt   = '0;
        end else if (w_goal) begin
          if (r_level < LVL_MAX) begin
            w_state_nxt    = LEVEL_UP;
            w_level_nxt    = r_level + 4'd1;
            w_level_up_nxt = 1'b1;
            w_cnt_nxt      = '0;
          end else begin
            w_state_nxt = WIN;
          end
        end
      end
      LEVEL_UP: begin
        if (i_collision) begin
          w_state_nxt = GAME_OVER;
          w_level_nxt = 4'd0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PLAYING;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      GAME_OVER: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = PLAYING;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      WIN: begin
        w_level_nxt = LVL_MAX;
      end
      default: begin
        w_state_nxt = PLAYING;
      end
    endcase
  end

  // Code 4'hF is out of digit range and drives the encoder blank.
  always_comb begin
    w_digit2 = r_level;
    if (r_state == LEVEL_UP && r_cnt < CNT_HALF) begin
      w_digit2 = 4'hF;
    end else if (r_state == GAME_OVER) begin
      w_digit2 = 4'd0;
    end
  end

`ifdef LEVEL_TRACKER_HIGH_SCORE_EN
  logic [3:0] r_best;

  always_ff @(posedge i_Clk) begin
    if (i_reset) begin
      r_best <= 4'd0;
    end else if (w_level_up_nxt && (w_level_nxt > r_best)) begin
      r_best <= w_level_nxt;
    end
  end

  assign w_digit1 = r_best;
`else
  assign w_digit1 = 4'hF;
`endif

  seven_seg_encoder u_seg_left (
    .i_value    (w_digit1),
    .o_segments (o_segment1)
  );

  seven_seg_encoder u_seg_right (
    .i_value    (w_digit2),
    .o_segments (o_segment2)
  );

  assign o_level     = r_level;
  assign o_level_up  = r_level_up;
  assign o_game_over = (r_state == GAME_OVER);
  assign o_win       = (r_state == WIN);

endmodule

// File: tb/tb_level_tracker.sv
// Directed, table-driven bench for level_tracker with FLASH_CYCLES=8.
// Also covers the best-level display when LEVEL_TRACKER_HIGH_SCORE_EN is defined.
module tb_level_tracker;

  localparam int FLASH = 8;
  localparam logic [6:0] BLANK = 7'h7F;

  logic       clk;
  logic       rst;
  logic [3:0] playerY;
  logic       collision;
  logic [3:0] level;
  logic       levelUp;
  logic       gameOver;
  logic       win;
  logic [6:0] seg1;
  logic [6:0] seg2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       rst;
    logic [3:0] y;
    logic       col;
    logic [3:0] lvl;
    logic       up;
    logic       go;
    logic       win;
    logic [6:0] seg2;
  } vec_t;

  vec_t vecs[$];

  level_tracker #(
    .GOAL_ROW     (1),
    .MAX_LEVEL    (9),
    .FLASH_CYCLES (FLASH)
  ) dut (
    .i_Clk       (clk),
    .i_reset     (rst),
    .i_player_y  (playerY),
    .i_collision (collision),
    .o_level     (level),
    .o_level_up  (levelUp),
    .o_game_over (gameOver),
    .o_win       (win),
    .o_segment1  (seg1),
    .o_segment2  (seg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] expSeg1(input int best);
`ifdef LEVEL_TRACKER_HIGH_SCORE_EN
    return segOf(best);
`else
    return (best >= 0) ? 7'h7F : 7'h7F;
`endif
  endfunction

  task automatic applyStimulus(input logic r, input logic [3:0] y, input logic c);
    rst       = r;
    playerY   = y;
    collision = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eLvl, input logic eUp,
                             input logic eGo, input logic eWin, input logic [6:0] eSeg2);
    vectors++;
    if (level !== eLvl || levelUp !== eUp || gameOver !== eGo || win !== eWin || seg2 !== eSeg2) begin
      miscompares++;
      $display("[TB] FAIL %s: got lvl=%0d up=%b go=%b win=%b seg2=%b, expected lvl=%0d up=%b go=%b win=%b seg2=%b",
               name, level, levelUp, gameOver, win, seg2, eLvl, eUp, eGo, eWin, eSeg2);
    end
  endtask

  task automatic checkSeg1(input string name, input logic [6:0] eSeg1);
    vectors++;
    if (seg1 !== eSeg1) begin
      miscompares++;
      $display("[TB] FAIL %s: got seg1=%b, expected seg1=%b", name, seg1, eSeg1);
    end
  endtask

  task automatic addVec(input logic r, input logic [3:0] y, input logic c, input logic [3:0] l,
                        input logic u, input logic g, input logic w, input logic [6:0] s);
    vec_t v;
    v.rst = r; v.y = y; v.col = c; v.lvl = l; v.up = u; v.go = g; v.win = w; v.seg2 = s;
    vecs.push_back(v);
  endtask

  // Goal pulse from PLAYING followed by the whole flash phase.
  task automatic crossAndFlash(input logic [3:0] newLvl);
    applyStimulus(1'b0, 4'd1, 1'b0);
    checkOutput("crossGoal", newLvl, 1'b1, 1'b0, 1'b0, BLANK);
    for (int k = 1; k < FLASH; k++) begin
      applyStimulus(1'b0, 4'd15, 1'b0);
      checkOutput("crossFlash", newLvl, 1'b0, 1'b0, 1'b0, (k < FLASH / 2) ? BLANK : segOf(int'(newLvl)));
    end
    applyStimulus(1'b0, 4'd15, 1'b0);
    checkOutput("crossDone", newLvl, 1'b0, 1'b0, 1'b0, segOf(int'(newLvl)));
  endtask

  // Seven more GAME_OVER cycles, then back to PLAYING at level 0.
  task automatic finishGameOver(input string name, input int goalAt);
    for (int k = 1; k < FLASH; k++) begin
      applyStimulus(1'b0, (k == goalAt) ? 4'd1 : 4'd15, 1'b0);
      checkOutput(name, 4'd0, 1'b0, 1'b1, 1'b0, segOf(0));
    end
    applyStimulus(1'b0, 4'd15, 1'b0);
    checkOutput({name, "Exit"}, 4'd0, 1'b0, 1'b0, 1'b0, segOf(0));
  endtask

  initial begin
    rst = 1'b1; playerY = 4'd15; collision = 1'b0;

    addVec(1, 15, 0, 0, 0, 0, 0, segOf(0));
    addVec(0, 15, 0, 0, 0, 0, 0, segOf(0));
    addVec(0, 15, 0, 0, 0, 0, 0, segOf(0));
    addVec(0,  1, 0, 1, 1, 0, 0, BLANK);
    addVec(0,  1, 0, 1, 0, 0, 0, BLANK);
    addVec(0, 15, 0, 1, 0, 0, 0, BLANK);
    addVec(0, 15, 0, 1, 0, 0, 0, BLANK);
    addVec(0, 15, 0, 1, 0, 0, 0, segOf(1));
    addVec(0, 15, 0, 1, 0, 0, 0, segOf(1));
    addVec(0, 15, 0, 1, 0, 0, 0, segOf(1));
    addVec(0, 15, 0, 1, 0, 0, 0, segOf(1));
    addVec(0, 15, 0, 1, 0, 0, 0, segOf(1));
    addVec(0, 15, 0, 1, 0, 0, 0, segOf(1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].y, vecs[i].col);
      checkOutput($sformatf("table%0d", i), vecs[i].lvl, vecs[i].up, vecs[i].go, vecs[i].win, vecs[i].seg2);
    end
    checkSeg1("seg1AfterReset", expSeg1(0));

    // Collision at level 3, goal pulse during GAME_OVER ignored.
    crossAndFlash(4'd2);
    crossAndFlash(4'd3);
    applyStimulus(1'b0, 4'd15, 1'b1);
    checkOutput("collideL3", 4'd0, 1'b0, 1'b1, 1'b0, segOf(0));
    finishGameOver("gameOverL3", 3);

    // Goal and collision together at level 2.
    crossAndFlash(4'd1);
    crossAndFlash(4'd2);
    applyStimulus(1'b0, 4'd1, 1'b1);
    checkOutput("goalAndCollide", 4'd0, 1'b0, 1'b1, 1'b0, segOf(0));
    finishGameOver("gameOverBoth", 0);

    // Collision in the middle of the flash phase.
    applyStimulus(1'b0, 4'd1, 1'b0);
    checkOutput("midFlashGoal", 4'd1, 1'b1, 1'b0, 1'b0, BLANK);
    applyStimulus(1'b0, 4'd15, 1'b0);
    checkOutput("midFlashHold", 4'd1, 1'b0, 1'b0, 1'b0, BLANK);
    applyStimulus(1'b0, 4'd15, 1'b1);
    checkOutput("midFlashCollide", 4'd0, 1'b0, 1'b1, 1'b0, segOf(0));
    finishGameOver("gameOverMid", 0);

    // Reset in the middle of GAME_OVER.
    applyStimulus(1'b0, 4'd15, 1'b1);
    applyStimulus(1'b0, 4'd15, 1'b0);
    checkOutput("preResetGO", 4'd0, 1'b0, 1'b1, 1'b0, segOf(0));
    applyStimulus(1'b1, 4'd15, 1'b0);
    checkOutput("resetInGO", 4'd0, 1'b0, 1'b0, 1'b0, segOf(0));
    applyStimulus(1'b0, 4'd15, 1'b0);
    checkOutput("idleAfterReset", 4'd0, 1'b0, 1'b0, 1'b0, segOf(0));

    // Nine crossings, tenth wins; WIN ignores everything but reset.
    for (int l = 1; l <= 9; l++) crossAndFlash(4'(l));
    applyStimulus(1'b0, 4'd1, 1'b0);
    checkOutput("winEnter", 4'd9, 1'b0, 1'b0, 1'b1, segOf(9));
    applyStimulus(1'b0, 4'd15, 1'b0);
    checkOutput("winHold", 4'd9, 1'b0, 1'b0, 1'b1, segOf(9));
    applyStimulus(1'b0, 4'd1, 1'b0);
    checkOutput("winGoal", 4'd9, 1'b0, 1'b0, 1'b1, segOf(9));
    applyStimulus(1'b0, 4'd15, 1'b1);
    checkOutput("winCollide", 4'd9, 1'b0, 1'b0, 1'b1, segOf(9));
    checkSeg1("seg1AtWin", expSeg1(9));
    applyStimulus(1'b1, 4'd15, 1'b0);
    checkOutput("winReset", 4'd0, 1'b0, 1'b0, 1'b0, segOf(0));
    checkSeg1("seg1AfterWinReset", expSeg1(0));

    // Best level survives GAME_OVER and is cleared only by reset.
    applyStimulus(1'b0, 4'd15, 1'b0);
    for (int l = 1; l <= 4; l++) crossAndFlash(4'(l));
    checkSeg1("seg1AtL4", expSeg1(4));
    applyStimulus(1'b0, 4'd15, 1'b1);
    checkOutput("collideL4", 4'd0, 1'b0, 1'b1, 1'b0, segOf(0));
    checkSeg1("seg1AfterCollide", expSeg1(4));
    finishGameOver("gameOverL4", 0);
    crossAndFlash(4'd1);
    checkSeg1("seg1KeepsBest", expSeg1(4));
    applyStimulus(1'b1, 4'd15, 1'b0);
    checkOutput("finalReset", 4'd0, 1'b0, 1'b0, 1'b0, segOf(0));
    checkSeg1("seg1FinalReset", expSeg1(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
